mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. Sits directly downstream of EX and upstream of WB.
- Registers ex_to_mem_bus, then selects and aligns load data from the synchronous data SRAM (lb/lbu/lh/lhu/lw) and produces the final register-file write value.
- Passes HI/LO write requests through to WB.
- Drives forwarding buses back to ID for both GPR and HI/LO values.

Parameters:
- EX_TO_MEM_WD, 147, width of incoming bus (`EX_TO_MEM_WD in defines.vh)
- MEM_TO_WB_WD, 136, width of outgoing bus (`MEM_TO_WB_WD)
- STALL_WD, 6, width of stall bus (`StallBus)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  clears the pipeline register
- stall  in  STALL_WD  stall vector; bit3 = MEM register hold, bit4 = WB register hold; `Stop=1
- ex_to_mem_bus  in  147  {hilo_bus[146:81], mem_op[80:76], pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}
- data_sram_rdata  in  32  SRAM read data, valid the cycle after EX drives the address
- mem_to_wb_bus  out  136  {hilo_bus[135:70], pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}
- mem_to_id_fwd  out  38  {rf_we, rf_waddr, rf_wdata}
- mem_to_id_hilo_fwd  out  66  {hi_we, lo_we, hi_data, lo_data}

Behaviour:
Pipeline register bus_r (priority order):
- rst -> 0.
- else flush -> 0.
- else stall[3]=Stop and stall[4]=NoStop -> 0 (bubble).
- else stall[3]=NoStop -> ex_to_mem_bus.
- else hold.

Reset values:
- All outputs are 0 after reset.
- A zero bus_r means rf_we=0 and hi_we=lo_we=0, so every output is effectively a NOP.

mem_op field:
- Bit mapping: {lb, lbu, lh, lhu, lw} = mem_op[4:0].
- One-hot or zero. A value with more than one bit set is illegal; the result is don't-care but must not assert X on outputs.

Load data select, using addr = ex_result[1:0]:
- lb: byte at addr, sign-extended.
- lbu: byte at addr, zero-extended.
- lh: addr[1]=0 -> bits 15:0, addr[1]=1 -> bits 31:16; sign-extended. Ignore addr[0].
- lhu: as lh, zero-extended.
- lw: full word. Ignore addr[1:0].
- Byte lanes: addr 00 = bits 7:0, 01 = 15:8, 10 = 23:16, 11 = 31:24 (little-endian).

rf_wdata:
- sel_rf_res=1 and mem_op≠0 -> load result.
- Otherwise -> ex_result.
- Fully combinational from bus_r and the selected read data.

Read-data hold (SRAM output is only valid in the first MEM cycle):
- rdata_hold (32b) and hold_vld (1b), both cleared by rst/flush.
- First cycle MEM is stalled (stall[3]=Stop and hold_vld=0): capture data_sram_rdata, set hold_vld=1.
- While hold_vld=1: the load path uses rdata_hold instead of data_sram_rdata.
- hold_vld clears on the cycle bus_r accepts new data (stall[3]=NoStop), on a bubble insert, or on flush.
- Stall on the very cycle of entry captures the correct (first) rdata.

Forwarding and pass-through:
- Forwarding outputs mirror mem_to_wb_bus fields combinationally, same cycle.
- hilo_bus passes through unmodified.
- Stores (data_ram_wen≠0): rf_we is already 0 from EX; MEM does not alter it.

Simultaneous events:
- flush overrides stall.
- rst overrides all.
- Reset mid-stall discards held data.

Latency:
- 1 cycle register from ex_to_mem_bus to mem_to_wb_bus, plus combinational select.

Decomposition:
- Shared defines.vh gains:
  - `EX_TO_MEM_WD=147 and `MEM_TO_WB_WD=136
  - mem_op bit indices `MEM_LB..`MEM_LW
  - `Stop/`NoStop reuse
- One sub-module, load_align: purely combinational. Inputs: mem_op, addr[1:0], rdata. Output: 32b extended data.
- The pipeline register and hold logic stay in mem_stage.

Test Plan:
- lb, addr=..03, rdata=0x80FF1234 -> rf_wdata=0xFFFFFF80. lbu same stimulus -> 0x00000080.
- lh, addr=..02, rdata=0x8001_7FFF -> 0xFFFF8001. lhu, addr=..00, same rdata -> 0x00007FFF.
- lw, rdata=0xDEADBEEF, rf_waddr=5 -> wb bus rf_we=1, waddr=5, wdata=0xDEADBEEF; mem_to_id_fwd equal the same cycle.
- Read-data hold:
  - Stimulus: lw enters MEM with rdata=0x11112222; stall[3]=Stop for 3 cycles; SRAM output changes to 0x33334444 after the first cycle.
  - Response: rf_wdata stays 0x11112222 throughout; on release the next instruction uses live rdata.
- Bubble, then flush:
  - stall[3]=Stop, stall[4]=NoStop -> next cycle wb bus all-zero.
  - flush together with stall[3]=NoStop and valid input -> bus_r=0 and hold_vld=0.
- ALU op (sel_rf_res=0, ex_result=0x00000042) with hilo_bus {1,1,0xA,0xB} -> wdata=0x42; hilo passthrough and hilo forwarding show hi=0xA, lo=0xB.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared widths, mem_op bit indices, stall encodings and bus
//               layouts for the MEM pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    // Bus widths shared with the EX and WB stages
    localparam int c_EX_TO_MEM_WD = 147;
    localparam int c_MEM_TO_WB_WD = 136;
    localparam int c_STALL_WD     = 6;

    // mem_op bit positions, {lb, lbu, lh, lhu, lw} = mem_op[4:0]
    localparam int c_MEM_LB  = 4;
    localparam int c_MEM_LBU = 3;
    localparam int c_MEM_LH  = 2;
    localparam int c_MEM_LHU = 1;
    localparam int c_MEM_LW  = 0;

    // Stall vector encodings and the bits MEM looks at
    localparam logic c_STOP      = 1'b1;
    localparam logic c_NO_STOP   = 1'b0;
    localparam int   c_STALL_MEM = 3;
    localparam int   c_STALL_WB  = 4;

    // HI/LO write request carried alongside the instruction
    typedef struct packed {
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi_data;
        logic [31:0] lo_data;
    } hilo_t;

    // Field view of ex_to_mem_bus (MSB first)
    typedef struct packed {
        hilo_t       hilo;
        logic [4:0]  mem_op;
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    // Sign- or zero-extend a byte
    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    // Sign- or zero-extend a halfword
    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational load data lane select and extension for
//               lb/lbu/lh/lhu/lw using the low two address bits.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import mem_stage_pkg::*;
(
    input  logic [4:0]  mem_op_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte lane (little-endian)
    always_comb begin
        w_byte = rdata_i[7:0];
        case (addr_i)
            2'b00:   w_byte = rdata_i[7:0];
            2'b01:   w_byte = rdata_i[15:8];
            2'b10:   w_byte = rdata_i[23:16];
            default: w_byte = rdata_i[31:24];
        endcase
    end

    // Halfword lane follows addr[1] only; addr[0] is ignored
    assign w_half = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Priority chain keeps multi-hot (illegal) mem_op X-free
    always_comb begin
        data_o = 32'h0;
        if (mem_op_i[c_MEM_LB])
            data_o = ext8(w_byte, 1'b1);
        else if (mem_op_i[c_MEM_LBU])
            data_o = ext8(w_byte, 1'b0);
        else if (mem_op_i[c_MEM_LH])
            data_o = ext16(w_half, 1'b1);
        else if (mem_op_i[c_MEM_LHU])
            data_o = ext16(w_half, 1'b0);
        else if (mem_op_i[c_MEM_LW])
            data_o = rdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MEM stage of the 5-stage MIPS pipeline. Registers the EX
//               bus, aligns SRAM load data (holding it across stalls),
//               produces the register write value and drives forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int EX_TO_MEM_WD = c_EX_TO_MEM_WD,
    parameter int MEM_TO_WB_WD = c_MEM_TO_WB_WD,
    parameter int STALL_WD     = c_STALL_WD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [37:0]             mem_to_id_fwd,
    output logic [65:0]             mem_to_id_hilo_fwd
);

    ex_to_mem_t  bus_q, bus_d;
    logic [31:0] rdata_hold_q, rdata_hold_d;
    logic        hold_vld_q, hold_vld_d;

    logic        w_mem_stop;
    logic        w_bubble;
    logic [31:0] w_rdata;
    logic [31:0] w_load_data;
    logic [31:0] w_rf_wdata;
    logic        w_unused;

    assign w_mem_stop = (stall[c_STALL_MEM] == c_STOP);
    assign w_bubble   = w_mem_stop && (stall[c_STALL_WB] == c_NO_STOP);

    // Pipeline register next state: flush, then bubble, then accept, else hold
    always_comb begin
        bus_d = bus_q;
        if (flush)
            bus_d = '0;
        else if (w_bubble)
            bus_d = '0;
        else if (!w_mem_stop)
            bus_d = ex_to_mem_bus;
    end

    // Pipeline register
    always_ff @(posedge clk) begin
        if (rst)
            bus_q <= '0;
        else
            bus_q <= bus_d;
    end

    // SRAM data is only valid in the first MEM cycle; capture it when the
    // stage stalls so the load result stays stable until the stall lifts
    always_comb begin
        hold_vld_d   = hold_vld_q;
        rdata_hold_d = rdata_hold_q;
        if (flush) begin
            hold_vld_d   = 1'b0;
            rdata_hold_d = 32'h0;
        end else if (w_bubble || !w_mem_stop) begin
            hold_vld_d   = 1'b0;
        end else if (!hold_vld_q) begin
            hold_vld_d   = 1'b1;
            rdata_hold_d = data_sram_rdata;
        end
    end

    // Read-data hold registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld_q   <= 1'b0;
            rdata_hold_q <= 32'h0;
        end else begin
            hold_vld_q   <= hold_vld_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    assign w_rdata = hold_vld_q ? rdata_hold_q : data_sram_rdata;

    load_align u_load_align (
        .mem_op_i (bus_q.mem_op),
        .addr_i   (bus_q.ex_result[1:0]),
        .rdata_i  (w_rdata),
        .data_o   (w_load_data)
    );

    // Register write value: load result only for real loads
    always_comb begin
        w_rf_wdata = bus_q.ex_result;
        if (bus_q.sel_rf_res && (bus_q.mem_op != 5'b0))
            w_rf_wdata = w_load_data;
    end

    assign mem_to_wb_bus      = {bus_q.hilo, bus_q.pc, bus_q.rf_we,
                                 bus_q.rf_waddr, w_rf_wdata};
    assign mem_to_id_fwd      = {bus_q.rf_we, bus_q.rf_waddr, w_rf_wdata};
    assign mem_to_id_hilo_fwd = bus_q.hilo;

    // Store controls and other stages' stall bits are not used here
    assign w_unused = ^{bus_q.data_ram_en, bus_q.data_ram_wen,
                        stall[2:0], stall[STALL_WD-1:5]};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed self-checking bench for mem_stage with a queue of
//               expected WB bus values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [5:0]   stall;
    logic [146:0] ex_to_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic [135:0] mem_to_wb_bus;
    logic [37:0]  mem_to_id_fwd;
    logic [65:0]  mem_to_id_hilo_fwd;

    typedef struct {
        string        tag;
        logic [135:0] wb;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [5:0] c_RUN    = 6'b000000;
    localparam logic [5:0] c_HOLD   = 6'b011111;
    localparam logic [5:0] c_BUBBLE = 6'b001111;

    mem_stage dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .stall              (stall),
        .ex_to_mem_bus      (ex_to_mem_bus),
        .data_sram_rdata    (data_sram_rdata),
        .mem_to_wb_bus      (mem_to_wb_bus),
        .mem_to_id_fwd      (mem_to_id_fwd),
        .mem_to_id_hilo_fwd (mem_to_id_hilo_fwd)
    );

    always #5 clk = ~clk;

    function automatic logic [146:0] mk_ex(input logic [65:0] hilo, input logic [4:0] op,
                                           input logic [31:0] pc, input logic en,
                                           input logic [3:0] wen, input logic sel,
                                           input logic we, input logic [4:0] waddr,
                                           input logic [31:0] res);
        return {hilo, op, pc, en, wen, sel, we, waddr, res};
    endfunction

    function automatic logic [135:0] mk_wb(input logic [65:0] hilo, input logic [31:0] pc,
                                           input logic we, input logic [4:0] waddr,
                                           input logic [31:0] wdata);
        return {hilo, pc, we, waddr, wdata};
    endfunction

    task automatic expect_wb(input string tag, input logic [135:0] wb);
        exp_t e;
        e.tag = tag;
        e.wb  = wb;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out();
        exp_t e;
        #1;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL scoreboard_empty got=%0d expected=nonzero", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            total++;
            assert (mem_to_wb_bus === e.wb) else begin
                bad++;
                $error("FAIL %s wb got=%h expected=%h", e.tag, mem_to_wb_bus, e.wb);
            end
            total++;
            assert (mem_to_id_fwd === e.wb[37:0]) else begin
                bad++;
                $error("FAIL %s fwd got=%h expected=%h", e.tag, mem_to_id_fwd, e.wb[37:0]);
            end
            total++;
            assert (mem_to_id_hilo_fwd === e.wb[135:70]) else begin
                bad++;
                $error("FAIL %s hilo_fwd got=%h expected=%h", e.tag, mem_to_id_hilo_fwd,
                       e.wb[135:70]);
            end
        end
    endtask

    initial begin
        logic [65:0] hl;
        hl = {1'b1, 1'b1, 32'h0000_000A, 32'h0000_000B};

        rst = 1'b1; flush = 1'b0; stall = c_RUN;
        ex_to_mem_bus = mk_ex(66'h0, 5'b00001, 32'h50, 1'b1, 4'h0, 1'b1, 1'b1, 5'd1, 32'h4);
        data_sram_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        expect_wb("reset", 136'h0);
        check_out();
        rst = 1'b0;

        // lb addr 3
        ex_to_mem_bus = mk_ex(66'h0, 5'b10000, 32'h100, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3, 32'h1003);
        expect_wb("lb", mk_wb(66'h0, 32'h100, 1'b1, 5'd3, 32'hFFFF_FF80));
        tick(); data_sram_rdata = 32'h80FF_1234; check_out();

        // lbu addr 3
        ex_to_mem_bus = mk_ex(66'h0, 5'b01000, 32'h104, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3, 32'h1003);
        expect_wb("lbu", mk_wb(66'h0, 32'h104, 1'b1, 5'd3, 32'h0000_0080));
        tick(); check_out();

        // lh addr 2
        ex_to_mem_bus = mk_ex(66'h0, 5'b00100, 32'h108, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4, 32'h1002);
        expect_wb("lh", mk_wb(66'h0, 32'h108, 1'b1, 5'd4, 32'hFFFF_8001));
        tick(); data_sram_rdata = 32'h8001_7FFF; check_out();

        // lhu addr 0
        ex_to_mem_bus = mk_ex(66'h0, 5'b00010, 32'h10C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4, 32'h1000);
        expect_wb("lhu", mk_wb(66'h0, 32'h10C, 1'b1, 5'd4, 32'h0000_7FFF));
        tick(); check_out();

        // lw to r5
        ex_to_mem_bus = mk_ex(66'h0, 5'b00001, 32'h110, 1'b1, 4'h0, 1'b1, 1'b1, 5'd5, 32'h1004);
        expect_wb("lw", mk_wb(66'h0, 32'h110, 1'b1, 5'd5, 32'hDEAD_BEEF));
        tick(); data_sram_rdata = 32'hDEAD_BEEF; check_out();

        // lb addr 1, lh addr 3 (addr[0] ignored), lw addr 2 (ignored)
        ex_to_mem_bus = mk_ex(66'h0, 5'b10000, 32'h114, 1'b1, 4'h0, 1'b1, 1'b1, 5'd2, 32'h1001);
        expect_wb("lb_a1", mk_wb(66'h0, 32'h114, 1'b1, 5'd2, 32'h0000_007F));
        tick(); data_sram_rdata = 32'h0000_7F00; check_out();
        ex_to_mem_bus = mk_ex(66'h0, 5'b00100, 32'h118, 1'b1, 4'h0, 1'b1, 1'b1, 5'd2, 32'h1003);
        expect_wb("lh_a3", mk_wb(66'h0, 32'h118, 1'b1, 5'd2, 32'hFFFF_FFFE));
        tick(); data_sram_rdata = 32'hFFFE_0000; check_out();
        ex_to_mem_bus = mk_ex(66'h0, 5'b00001, 32'h11C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd2, 32'h1002);
        expect_wb("lw_a2", mk_wb(66'h0, 32'h11C, 1'b1, 5'd2, 32'h1234_5678));
        tick(); data_sram_rdata = 32'h1234_5678; check_out();

        // Read-data hold: stall on entry for three cycles, SRAM changes after the first
        ex_to_mem_bus = mk_ex(66'h0, 5'b00001, 32'h120, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6, 32'h2000);
        expect_wb("hold_k1", mk_wb(66'h0, 32'h120, 1'b1, 5'd6, 32'h1111_2222));
        tick();
        data_sram_rdata = 32'h1111_2222; stall = c_HOLD;
        ex_to_mem_bus = mk_ex(66'h0, 5'b00001, 32'h124, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, 32'h2004);
        check_out();
        expect_wb("hold_k2", mk_wb(66'h0, 32'h120, 1'b1, 5'd6, 32'h1111_2222));
        tick(); data_sram_rdata = 32'h3333_4444; check_out();
        expect_wb("hold_k3", mk_wb(66'h0, 32'h120, 1'b1, 5'd6, 32'h1111_2222));
        tick(); check_out();
        expect_wb("hold_k4", mk_wb(66'h0, 32'h120, 1'b1, 5'd6, 32'h1111_2222));
        tick(); stall = c_RUN; check_out();
        expect_wb("hold_release", mk_wb(66'h0, 32'h124, 1'b1, 5'd7, 32'h3333_4444));
        tick(); check_out();

        // Bubble insert
        ex_to_mem_bus = mk_ex(66'h0, 5'b00000, 32'h130, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'h55);
        expect_wb("pre_bubble", mk_wb(66'h0, 32'h130, 1'b1, 5'd8, 32'h55));
        tick(); stall = c_BUBBLE; check_out();
        expect_wb("bubble", 136'h0);
        tick(); stall = c_RUN; check_out();

        // Flush with valid input and no stall
        ex_to_mem_bus = mk_ex(66'h0, 5'b00000, 32'h134, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'h66);
        flush = 1'b1;
        expect_wb("flush", 136'h0);
        tick(); flush = 1'b0; check_out();

        // Flush overrides a stall holding a load, then a fresh load uses live rdata
        ex_to_mem_bus = mk_ex(66'h0, 5'b00001, 32'h140, 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h3000);
        expect_wb("pre_flush_hold", mk_wb(66'h0, 32'h140, 1'b1, 5'd10, 32'hAAAA_5555));
        tick(); data_sram_rdata = 32'hAAAA_5555; stall = c_HOLD; check_out();
        flush = 1'b1;
        expect_wb("flush_over_stall", 136'h0);
        tick(); flush = 1'b0; stall = c_RUN; data_sram_rdata = 32'hCCCC_DDDD; check_out();
        ex_to_mem_bus = mk_ex(66'h0, 5'b00001, 32'h144, 1'b1, 4'h0, 1'b1, 1'b1, 5'd11, 32'h3004);
        expect_wb("post_flush_lw", mk_wb(66'h0, 32'h144, 1'b1, 5'd11, 32'h0BAD_F00D));
        tick(); data_sram_rdata = 32'h0BAD_F00D; check_out();

        // Reset mid-stall discards the held load
        ex_to_mem_bus = mk_ex(66'h0, 5'b00001, 32'h150, 1'b1, 4'h0, 1'b1, 1'b1, 5'd12, 32'h3008);
        expect_wb("pre_rst_hold", mk_wb(66'h0, 32'h150, 1'b1, 5'd12, 32'h1234_5678));
        tick(); data_sram_rdata = 32'h1234_5678; stall = c_HOLD; check_out();
        rst = 1'b1;
        expect_wb("rst_mid_stall", 136'h0);
        tick(); rst = 1'b0; stall = c_RUN; check_out();
        ex_to_mem_bus = mk_ex(66'h0, 5'b00001, 32'h154, 1'b1, 4'h0, 1'b1, 1'b1, 5'd13, 32'h300C);
        expect_wb("post_rst_lw", mk_wb(66'h0, 32'h154, 1'b1, 5'd13, 32'h9ABC_DEF0));
        tick(); data_sram_rdata = 32'h9ABC_DEF0; check_out();

        // ALU op with HI/LO write request
        ex_to_mem_bus = mk_ex(hl, 5'b00000, 32'h160, 1'b0, 4'h0, 1'b0, 1'b1, 5'd14, 32'h42);
        expect_wb("alu_hilo", mk_wb(hl, 32'h160, 1'b1, 5'd14, 32'h42));
        tick(); data_sram_rdata = 32'h5A5A_5A5A; check_out();

        // Store: rf_we stays 0, wdata is ex_result
        ex_to_mem_bus = mk_ex(66'h0, 5'b00000, 32'h164, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h4000);
        expect_wb("store", mk_wb(66'h0, 32'h164, 1'b0, 5'd0, 32'h4000));
        tick(); check_out();

        // sel_rf_res set without a load op selects ex_result
        ex_to_mem_bus = mk_ex(66'h0, 5'b00000, 32'h168, 1'b0, 4'h0, 1'b1, 1'b1, 5'd15, 32'h77);
        expect_wb("sel_no_op", mk_wb(66'h0, 32'h168, 1'b1, 5'd15, 32'h77));
        tick(); data_sram_rdata = 32'hFFFF_FFFF; check_out();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
